// File: rtl/ripemd160_msg_sched.sv
// RIPEMD-160 message scheduler: pads one SHA-256 digest into a little-endian 512-bit block,
// then streams the left/right line words X[r(j)] / X[r'(j)] one round per accepted handshake.
module ripemd160_msg_sched #(
    parameter int ROUNDS   = 80,
    parameter int MSG_BITS = 256
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_digest,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [6:0]   out_round,
    output logic [31:0]  out_wl,
    output logic [31:0]  out_wr,
    output logic         out_last,
    output logic         busy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; a held valid
    // keeps its payload stable until that edge.
    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    localparam logic [6:0] LAST_J = 7'(ROUNDS - 1);

    localparam logic [3:0] R_TBL [0:79] = '{
        4'd0,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6,  4'd7,
        4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15,
        4'd7,  4'd4,  4'd13, 4'd1,  4'd10, 4'd6,  4'd15, 4'd3,
        4'd12, 4'd0,  4'd9,  4'd5,  4'd2,  4'd14, 4'd11, 4'd8,
        4'd3,  4'd10, 4'd14, 4'd4,  4'd9,  4'd15, 4'd8,  4'd1,
        4'd2,  4'd7,  4'd0,  4'd6,  4'd13, 4'd11, 4'd5,  4'd12,
        4'd1,  4'd9,  4'd11, 4'd10, 4'd0,  4'd8,  4'd12, 4'd4,
        4'd13, 4'd3,  4'd7,  4'd15, 4'd14, 4'd5,  4'd6,  4'd2,
        4'd4,  4'd0,  4'd5,  4'd9,  4'd7,  4'd12, 4'd2,  4'd10,
        4'd14, 4'd1,  4'd3,  4'd8,  4'd11, 4'd6,  4'd15, 4'd13
    };

    localparam logic [3:0] RP_TBL [0:79] = '{
        4'd5,  4'd14, 4'd7,  4'd0,  4'd9,  4'd2,  4'd11, 4'd4,
        4'd13, 4'd6,  4'd15, 4'd8,  4'd1,  4'd10, 4'd3,  4'd12,
        4'd6,  4'd11, 4'd3,  4'd7,  4'd0,  4'd13, 4'd5,  4'd10,
        4'd14, 4'd15, 4'd8,  4'd12, 4'd4,  4'd9,  4'd1,  4'd2,
        4'd15, 4'd5,  4'd1,  4'd3,  4'd7,  4'd14, 4'd6,  4'd9,
        4'd11, 4'd8,  4'd12, 4'd2,  4'd10, 4'd0,  4'd4,  4'd13,
        4'd8,  4'd6,  4'd4,  4'd1,  4'd3,  4'd11, 4'd15, 4'd0,
        4'd5,  4'd12, 4'd2,  4'd13, 4'd9,  4'd7,  4'd10, 4'd14,
        4'd12, 4'd15, 4'd10, 4'd4,  4'd1,  4'd5,  4'd8,  4'd7,
        4'd6,  4'd2,  4'd13, 4'd14, 4'd0,  4'd3,  4'd9,  4'd11
    };

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    state_t      state_q, state_d;
    logic [6:0]  j_q, j_d;
    logic [31:0] x_q [16];
    logic [31:0] x_d [16];
    logic        capture;
    logic        advance;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_STREAM);
    assign busy      = (state_q == S_STREAM);
    assign capture   = in_valid && in_ready;
    assign advance   = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        for (int i = 0; i < 16; i++) begin
            x_d[i] = x_q[i];
        end
        if (capture) begin
            state_d = S_STREAM;
            j_d     = 7'd0;
            for (int i = 0; i < 8; i++) begin
                x_d[i] = bswap32(in_digest[255-32*i -: 32]);
            end
            for (int i = 8; i < 16; i++) begin
                x_d[i] = 32'h0;
            end
            x_d[8]  = 32'h0000_0080;
            x_d[14] = 32'(MSG_BITS);
        end else if (advance) begin
            if (j_q == LAST_J) begin
                state_d = S_IDLE;
                j_d     = 7'd0;
            end else begin
                j_d = j_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            j_q     <= 7'd0;
            for (int i = 0; i < 16; i++) begin
                x_q[i] <= 32'h0;
            end
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            for (int i = 0; i < 16; i++) begin
                x_q[i] <= x_d[i];
            end
        end
    end

    // Words are read straight out of the block registers, so a stall holds them for free.
    assign out_round = j_q;
    assign out_wl    = x_q[R_TBL[j_q]];
    assign out_wr    = x_q[RP_TBL[j_q]];
    assign out_last  = out_valid && (j_q == LAST_J);

endmodule

// File: tb/tb_ripemd160_msg_sched.sv
// Directed bench for ripemd160_msg_sched: table of hand-computed round words plus
// sequences for latency, backpressure, collision with a held in_valid, and mid-stream reset.
module tb_ripemd160_msg_sched;

    localparam int ROUNDS = 80;
    localparam logic [255:0] D_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_COUNT =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    localparam int R_TBL [80] = '{
        0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
        7, 4, 13, 1, 10, 6, 15, 3, 12, 0, 9, 5, 2, 14, 11, 8,
        3, 10, 14, 4, 9, 15, 8, 1, 2, 7, 0, 6, 13, 11, 5, 12,
        1, 9, 11, 10, 0, 8, 12, 4, 13, 3, 7, 15, 14, 5, 6, 2,
        4, 0, 5, 9, 7, 12, 2, 10, 14, 1, 3, 8, 11, 6, 15, 13
    };
    localparam int RP_TBL [80] = '{
        5, 14, 7, 0, 9, 2, 11, 4, 13, 6, 15, 8, 1, 10, 3, 12,
        6, 11, 3, 7, 0, 13, 5, 10, 14, 15, 8, 12, 4, 9, 1, 2,
        15, 5, 1, 3, 7, 14, 6, 9, 11, 8, 12, 2, 10, 0, 4, 13,
        8, 6, 4, 1, 3, 11, 15, 0, 5, 12, 2, 13, 9, 7, 10, 14,
        12, 15, 10, 4, 1, 5, 8, 7, 6, 2, 13, 14, 0, 3, 9, 11
    };

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_digest;
    logic         out_valid;
    logic         out_ready;
    logic [6:0]   out_round;
    logic [31:0]  out_wl;
    logic [31:0]  out_wr;
    logic         out_last;
    logic         busy;

    always #5 clk = ~clk;

    ripemd160_msg_sched #(.ROUNDS(ROUNDS), .MSG_BITS(256)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digest (in_digest),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_round (out_round),
        .out_wl    (out_wl),
        .out_wr    (out_wr),
        .out_last  (out_last),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cur_j    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected block word, built independently of the DUT from the digest.
    function automatic logic [31:0] mword(input logic [255:0] d, input int idx);
        logic [31:0] w;
        if (idx < 8) begin
            w = d[255-32*idx -: 32];
            return {w[7:0], w[15:8], w[23:16], w[31:24]};
        end
        if (idx == 8) return 32'h0000_0080;
        if (idx == 14) return 32'h0000_0100;
        return 32'h0;
    endfunction

    // All tasks are entered and left at a falling edge.
    task automatic capture(input logic [255:0] d);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("capture_wait_in_ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_digest = d;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cur_j    = 0;
        check("capture_latency_valid", 32'(out_valid), 32'd1);
        check("capture_latency_round", 32'(out_round), 32'd0);
    endtask

    task automatic step();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        cur_j++;
    endtask

    task automatic drain();
        while (cur_j < ROUNDS) step();
        check("drain_in_ready", 32'(in_ready), 32'd1);
        check("drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    typedef struct {
        logic [255:0] digest;
        int           round;
        logic [31:0]  wl;
        logic [31:0]  wr;
        logic         last;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic [255:0] cur_d;
        bit           loaded;
        int           hs;
        int           cycles;
        int           j;
        logic         stalled;
        logic [6:0]   p_round;
        logic [31:0]  p_wl;
        logic [31:0]  p_wr;
        logic         p_last;

        vecs[0]  = '{D_EMPTY, 0,  32'h42c4b0e3, 32'h4c939b64, 1'b0};
        vecs[1]  = '{D_EMPTY, 1,  32'h141cfc98, 32'h00000100, 1'b0};
        vecs[2]  = '{D_EMPTY, 8,  32'h00000080, 32'h00000000, 1'b0};
        vecs[3]  = '{D_EMPTY, 14, 32'h00000100, 32'h24b96f99, 1'b0};
        vecs[4]  = '{D_EMPTY, 16, 32'h55b85278, 32'h1b9995a4, 1'b0};
        vecs[5]  = '{D_EMPTY, 79, 32'h00000000, 32'h00000000, 1'b1};
        vecs[6]  = '{D_COUNT, 0,  32'h03020100, 32'h17161514, 1'b0};
        vecs[7]  = '{D_COUNT, 16, 32'h1f1e1d1c, 32'h1b1a1918, 1'b0};
        vecs[8]  = '{D_COUNT, 20, 32'h00000000, 32'h03020100, 1'b0};
        vecs[9]  = '{D_COUNT, 32, 32'h0f0e0d0c, 32'h00000000, 1'b0};
        vecs[10] = '{D_COUNT, 48, 32'h07060504, 32'h00000080, 1'b0};
        vecs[11] = '{D_COUNT, 64, 32'h13121110, 32'h00000000, 1'b0};
        vecs[12] = '{D_COUNT, 78, 32'h00000000, 32'h00000000, 1'b0};
        vecs[13] = '{D_COUNT, 79, 32'h00000000, 32'h00000000, 1'b1};

        // Reset state
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_digest = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_out_round", 32'(out_round), 32'd0);
        check("reset_out_wl", out_wl, 32'd0);
        check("reset_out_wr", out_wr, 32'd0);
        check("reset_out_last", 32'(out_last), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Table of hand-computed round words
        loaded = 1'b0;
        cur_d  = '0;
        for (int i = 0; i < 14; i++) begin
            if (!loaded || vecs[i].digest != cur_d) begin
                if (loaded) drain();
                capture(vecs[i].digest);
                cur_d  = vecs[i].digest;
                loaded = 1'b1;
            end
            while (cur_j < vecs[i].round) step();
            check($sformatf("vec%0d_round", i), 32'(out_round), 32'(vecs[i].round));
            check($sformatf("vec%0d_wl", i), out_wl, vecs[i].wl);
            check($sformatf("vec%0d_wr", i), out_wr, vecs[i].wr);
            check($sformatf("vec%0d_last", i), 32'(out_last), 32'(vecs[i].last));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
        end
        drain();

        // Full stream with out_ready held high: sequence and out_last position
        capture(D_EMPTY);
        out_ready = 1'b1;
        for (int k = 0; k < ROUNDS; k++) begin
            check("full_round", 32'(out_round), 32'(k));
            check("full_last", 32'(out_last), 32'(k == ROUNDS - 1));
            check("full_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("full_end_in_ready", 32'(in_ready), 32'd1);
        check("full_end_out_valid", 32'(out_valid), 32'd0);
        check("full_end_last", 32'(out_last), 32'd0);

        // Random backpressure
        capture(D_COUNT);
        hs      = 0;
        cycles  = 0;
        j       = 0;
        stalled = 1'b0;
        p_round = '0;
        p_wl    = '0;
        p_wr    = '0;
        p_last  = 1'b0;
        while (hs < ROUNDS && cycles < 2000) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_round", 32'(out_round), 32'(j));
            check("bp_wl", out_wl, mword(D_COUNT, R_TBL[j]));
            check("bp_wr", out_wr, mword(D_COUNT, RP_TBL[j]));
            check("bp_last", 32'(out_last), 32'(j == ROUNDS - 1));
            if (stalled) begin
                check("bp_hold_round", 32'(out_round), 32'(p_round));
                check("bp_hold_wl", out_wl, p_wl);
                check("bp_hold_wr", out_wr, p_wr);
                check("bp_hold_last", 32'(out_last), 32'(p_last));
            end
            p_round   = out_round;
            p_wl      = out_wl;
            p_wr      = out_wr;
            p_last    = out_last;
            out_ready = 1'($urandom_range(0, 1));
            stalled   = !out_ready;
            @(posedge clk);
            if (out_ready) begin
                hs++;
                j++;
            end
            @(negedge clk);
            cycles++;
        end
        out_ready = 1'b0;
        check("bp_handshakes", 32'(hs), 32'(ROUNDS));
        check("bp_end_in_ready", 32'(in_ready), 32'd1);
        check("bp_end_busy", 32'(busy), 32'd0);

        // Held in_valid: B must wait until the cycle after A's final handshake
        in_valid  = 1'b1;
        in_digest = D_EMPTY;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_digest = D_COUNT;
        for (int k = 0; k < ROUNDS; k++) begin
            check("coll_a_round", 32'(out_round), 32'(k));
            check("coll_a_wl", out_wl, mword(D_EMPTY, R_TBL[k]));
            check("coll_a_wr", out_wr, mword(D_EMPTY, RP_TBL[k]));
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("coll_gap_out_valid", 32'(out_valid), 32'd0);
        check("coll_gap_in_ready", 32'(in_ready), 32'd1);
        check("coll_gap_busy", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cur_j    = 0;
        check("coll_b_valid", 32'(out_valid), 32'd1);
        check("coll_b_round", 32'(out_round), 32'd0);
        check("coll_b_wl", out_wl, mword(D_COUNT, R_TBL[0]));
        check("coll_b_wr", out_wr, mword(D_COUNT, RP_TBL[0]));
        drain();

        // Reset in the middle of a stream
        capture(D_EMPTY);
        while (cur_j < 37) step();
        check("mid_round_37", 32'(out_round), 32'd37);
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_round", 32'(out_round), 32'd0);
        check("mid_rst_wl", out_wl, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        capture(D_COUNT);
        check("mid_new_wl0", out_wl, mword(D_COUNT, R_TBL[0]));
        check("mid_new_wr0", out_wr, mword(D_COUNT, RP_TBL[0]));
        step();
        check("mid_new_round1", 32'(out_round), 32'd1);
        check("mid_new_wl1", out_wl, mword(D_COUNT, R_TBL[1]));
        check("mid_new_wr1", out_wr, mword(D_COUNT, RP_TBL[1]));
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
